// File: rtl/cluster_pkg.sv
// Shared constants and the packed cluster word for the cluster pack/unpack path.
package cluster_pkg;

  localparam int NUM_STRIPS   = 1536;
  localparam int ADDR_W       = 11;
  localparam int SIZE_W       = 3;
  localparam int MAX_CLUSTERS = 8;
  localparam int CNT_W        = 8;
  localparam logic [ADDR_W-1:0] NULL_ADDR = 11'h7FF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
  } cluster_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } unpack_state_t;

endpackage

// File: rtl/cluster_strip_mask.sv
// Combinational strip mask: bits addr..addr+size set, clipped at NUM_STRIPS-1.
module cluster_strip_mask
  import cluster_pkg::*;
(
  input  logic [ADDR_W-1:0]     addr,
  input  logic [SIZE_W-1:0]     size,
  output logic [NUM_STRIPS-1:0] mask
);

  int lo;
  int hi;

  // Addresses at or above NUM_STRIPS produce an all-zero mask.
  always_comb begin
    mask = '0;
    lo   = int'(addr);
    hi   = int'(addr) + int'(size);
    for (int i = 0; i < NUM_STRIPS; i++) begin
      if (i >= lo && i <= hi) mask[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds the vpfs flag map, count and overflow from a framed stream of cluster words.
// Optional strip expansion into sbits: define CLUSTER_SIZE_EXPAND_EN.
module cluster_unpacker
  import cluster_pkg::*;
(
  input  logic                  clock4x,
  input  logic                  reset,
  input  logic                  clst_valid,
  input  logic [ADDR_W-1:0]     clst_addr,
  input  logic [SIZE_W-1:0]     clst_size,
  input  logic                  clst_last,
  output logic [NUM_STRIPS-1:0] vpfs,
  output logic [NUM_STRIPS-1:0] sbits,
  output logic [CNT_W-1:0]      cnt,
  output logic                  overflow,
  output logic                  frame_valid,
  output logic                  addr_err,
  output logic                  dup_err
);

  // Handshake: clst_valid alone qualifies a word; the block is always ready,
  // so every valid word is consumed in the cycle it is presented.
  cluster_t               word;
  unpack_state_t          state;
  logic [NUM_STRIPS-1:0]  acc;
  logic [NUM_STRIPS-1:0]  acc_next;
  logic [NUM_STRIPS-1:0]  onehot;
  logic [CNT_W-1:0]       acc_cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   is_null;
  logic                   in_range;
  logic                   dup;
  logic                   accept;
  logic                   close;

  assign word = '{addr: clst_addr, size: clst_size};

  cluster_strip_mask u_onehot (
    .addr (word.addr),
    .size ({SIZE_W{1'b0}}),
    .mask (onehot)
  );

  assign is_null  = (word.addr == NULL_ADDR);
  assign in_range = (word.addr < ADDR_W'(NUM_STRIPS));
  assign dup      = |(acc & onehot);
  assign accept   = clst_valid && in_range && !dup;
  assign close    = clst_valid && clst_last;
  assign acc_next = accept ? (acc | onehot) : acc;
  assign cnt_next = (accept && acc_cnt != {CNT_W{1'b1}}) ? acc_cnt + CNT_W'(1) : acc_cnt;

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      acc         <= '0;
      acc_cnt     <= '0;
      vpfs        <= '0;
      cnt         <= '0;
      overflow    <= 1'b0;
      frame_valid <= 1'b0;
      addr_err    <= 1'b0;
      dup_err     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      addr_err    <= clst_valid && !is_null && !in_range;
      dup_err     <= clst_valid && in_range && dup;

      case (state)
        ST_IDLE, ST_ACCUM: if (clst_valid) state <= clst_last ? ST_DONE : ST_ACCUM;
        ST_DONE:           state <= clst_valid ? (clst_last ? ST_DONE : ST_ACCUM) : ST_IDLE;
        default:           state <= ST_IDLE;
      endcase

      // The closing word's own contribution is folded into the published map.
      if (close) begin
        vpfs        <= acc_next;
        cnt         <= cnt_next;
        overflow    <= (cnt_next > CNT_W'(MAX_CLUSTERS));
        frame_valid <= 1'b1;
        acc         <= '0;
        acc_cnt     <= '0;
      end else begin
        acc     <= acc_next;
        acc_cnt <= cnt_next;
      end
    end
  end

`ifdef CLUSTER_SIZE_EXPAND_EN
  logic [NUM_STRIPS-1:0] size_mask;
  logic [NUM_STRIPS-1:0] acc_s;
  logic [NUM_STRIPS-1:0] acc_s_next;
  logic [NUM_STRIPS-1:0] sbits_q;

  cluster_strip_mask u_size_mask (
    .addr (word.addr),
    .size (word.size),
    .mask (size_mask)
  );

  // Expansion follows the same accept decision so it never alters cnt or dup detection.
  assign acc_s_next = accept ? (acc_s | size_mask) : acc_s;

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      acc_s   <= '0;
      sbits_q <= '0;
    end else if (close) begin
      sbits_q <= acc_s_next;
      acc_s   <= '0;
    end else begin
      acc_s <= acc_s_next;
    end
  end

  assign sbits = sbits_q;
`else
  assign sbits = vpfs;
`endif

endmodule

// File: tb/tb_cluster_unpacker.sv
// Directed bench for cluster_unpacker with hand-computed expected maps and counts.
module tb_cluster_unpacker;
  import cluster_pkg::*;

  localparam int N = NUM_STRIPS;

  logic                  clock4x;
  logic                  reset;
  logic                  clst_valid;
  logic [ADDR_W-1:0]     clst_addr;
  logic [SIZE_W-1:0]     clst_size;
  logic                  clst_last;
  logic [N-1:0]          vpfs;
  logic [N-1:0]          sbits;
  logic [CNT_W-1:0]      cnt;
  logic                  overflow;
  logic                  frame_valid;
  logic                  addr_err;
  logic                  dup_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [N-1:0] exp_map;
  logic [N-1:0] exp_sb;

  cluster_unpacker dut (
    .clock4x     (clock4x),
    .reset       (reset),
    .clst_valid  (clst_valid),
    .clst_addr   (clst_addr),
    .clst_size   (clst_size),
    .clst_last   (clst_last),
    .vpfs        (vpfs),
    .sbits       (sbits),
    .cnt         (cnt),
    .overflow    (overflow),
    .frame_valid (frame_valid),
    .addr_err    (addr_err),
    .dup_err     (dup_err)
  );

  // clock/reset
  initial clock4x = 1'b0;
  always #5 clock4x = ~clock4x;

  // checker: wide values are summarised so report lines stay short
  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    int first_diff;
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      first_diff = -1;
      for (int i = N - 1; i >= 0; i--) if (got[i] !== exp[i]) first_diff = i;
      $display("FAIL %s: got low=%h ones=%0d, expected low=%h ones=%0d, first differing bit %0d",
               tag, got[31:0], $countones(got), exp[31:0], $countones(exp), first_diff);
    end
  endtask

  // driver: inputs change on the falling edge; outputs of the previous word
  // are stable when this returns
  task automatic drive(input logic v, input logic [ADDR_W-1:0] a,
                       input logic [SIZE_W-1:0] s, input logic l);
    @(negedge clock4x);
    clst_valid = v;
    clst_addr  = a;
    clst_size  = s;
    clst_last  = l;
  endtask

  task automatic idle();
    drive(1'b0, 11'd0, 3'd0, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    clst_valid = 1'b0;
    clst_addr  = '0;
    clst_size  = '0;
    clst_last  = 1'b0;
    idle();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) idle();
    check("rst_vpfs",  vpfs, '0);
    check("rst_sbits", sbits, '0);
    check("rst_cnt",   N'(cnt), '0);
    check("rst_ovf",   N'(overflow), '0);
    check("rst_fv",    N'(frame_valid), '0);
    check("rst_aerr",  N'(addr_err), '0);
    check("rst_derr",  N'(dup_err), '0);

    // reset in the middle of a frame discards the partial accumulator
    drive(1'b1, 11'd20, 3'd0, 1'b0);
    drive(1'b1, 11'd30, 3'd0, 1'b0);
    #2 reset = 1'b1;
    idle();
    check("midrst_fv", N'(frame_valid), '0);
    reset = 1'b0;
    drive(1'b1, 11'd5, 3'd0, 1'b1);
    idle();
    exp_map = '0; exp_map[5] = 1'b1;
    check("midrst_fv1",  N'(frame_valid), N'(1));
    check("midrst_cnt",  N'(cnt), N'(1));
    check("midrst_vpfs", vpfs, exp_map);

    // three corner addresses, then a back-to-back overflowing frame
    drive(1'b1, 11'd0,    3'd0, 1'b0);
    drive(1'b1, 11'd767,  3'd0, 1'b0);
    drive(1'b1, 11'd1535, 3'd0, 1'b1);
    drive(1'b1, 11'd100,  3'd0, 1'b0);
    exp_map = '0; exp_map[0] = 1'b1; exp_map[767] = 1'b1; exp_map[1535] = 1'b1;
    check("f3_fv",    N'(frame_valid), N'(1));
    check("f3_vpfs",  vpfs, exp_map);
    check("f3_sbits", sbits, exp_map);
    check("f3_cnt",   N'(cnt), N'(3));
    check("f3_ovf",   N'(overflow), '0);
    for (int k = 2; k <= 9; k++) drive(1'b1, 11'(k * 100), 3'd0, k == 9);
    idle();
    exp_map = '0;
    for (int k = 1; k <= 9; k++) exp_map[k * 100] = 1'b1;
    check("f9_fv",   N'(frame_valid), N'(1));
    check("f9_vpfs", vpfs, exp_map);
    check("f9_cnt",  N'(cnt), N'(9));
    check("f9_ovf",  N'(overflow), N'(1));
    idle();
    check("f9_fv_drop",  N'(frame_valid), '0);
    check("f9_cnt_hold", N'(cnt), N'(9));
    check("f9_ovf_hold", N'(overflow), N'(1));

    // out-of-range, null and duplicate words
    drive(1'b1, 11'd1600, 3'd0, 1'b0);
    drive(1'b1, 11'h7FF,  3'd0, 1'b0);
    check("err_aerr1", N'(addr_err), N'(1));
    check("err_derr1", N'(dup_err), '0);
    drive(1'b1, 11'd10,   3'd0, 1'b0);
    check("err_null_aerr", N'(addr_err), '0);
    check("err_null_derr", N'(dup_err), '0);
    drive(1'b1, 11'd10,   3'd0, 1'b1);
    check("err_first10_derr", N'(dup_err), '0);
    idle();
    exp_map = '0; exp_map[10] = 1'b1;
    check("err_derr4", N'(dup_err), N'(1));
    check("err_fv",    N'(frame_valid), N'(1));
    check("err_cnt",   N'(cnt), N'(1));
    check("err_vpfs",  vpfs, exp_map);
    check("err_ovf",   N'(overflow), '0);

    // empty frame
    drive(1'b1, 11'h7FF, 3'd0, 1'b1);
    idle();
    check("empty_fv",   N'(frame_valid), N'(1));
    check("empty_cnt",  N'(cnt), '0);
    check("empty_vpfs", vpfs, '0);

    // last without valid must not close a frame
    drive(1'b0, 11'd40, 3'd0, 1'b1);
    idle();
    check("lastnv_fv", N'(frame_valid), '0);

    // size expansion near the top edge
    drive(1'b1, 11'd1533, 3'd7, 1'b0);
    drive(1'b1, 11'd100,  3'd2, 1'b1);
    idle();
    exp_map = '0; exp_map[100] = 1'b1; exp_map[1533] = 1'b1;
`ifdef CLUSTER_SIZE_EXPAND_EN
    exp_sb = '0;
    for (int i = 100; i <= 102; i++) exp_sb[i] = 1'b1;
    for (int i = 1533; i <= 1535; i++) exp_sb[i] = 1'b1;
`else
    exp_sb = exp_map;
`endif
    check("exp_fv",    N'(frame_valid), N'(1));
    check("exp_cnt",   N'(cnt), N'(2));
    check("exp_vpfs",  vpfs, exp_map);
    check("exp_sbits", sbits, exp_sb);

    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cluster_unpacker.md
Name: cluster_unpacker

Overview:
- Receive-side counterpart of the cluster counting/packing path.
- Accepts a serial stream of packed cluster words on clock4x, one word per cycle, framed by a last flag.
- Rebuilds the 1536-bit valid-pattern-flag map that the counter consumes, along with the cluster count and overflow flag.
- Used in the back end and in loopback tests. Its cnt/overflow must match the count path for the same vpfs.

Parameters:
- NUM_STRIPS, 1536, width of the reconstructed vpfs map; valid addresses are 0..NUM_STRIPS-1.
- MAX_CLUSTERS, 8, overflow asserts when the frame count exceeds this value.
- CNT_W, 8, width of cnt; saturates at 2^CNT_W-1.

Ports:
- clock4x  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- clst_valid  in  1  word present this cycle; block is always ready (no backpressure).
- clst_addr  in  11  strip address of cluster; 0x7FF = null/padding word.
- clst_size  in  3  cluster size minus one (0 = 1 strip).
- clst_last  in  1  final word of frame; qualified by clst_valid.
- vpfs  out  NUM_STRIPS  reconstructed flag map, one bit per accepted cluster address.
- sbits  out  NUM_STRIPS  strip map (see Optional Feature).
- cnt  out  CNT_W  accepted cluster count for frame.
- overflow  out  1  cnt > MAX_CLUSTERS.
- frame_valid  out  1  one-cycle strobe: outputs updated.
- addr_err  out  1  one-cycle strobe: a word with address in NUM_STRIPS..0x7FE was dropped.
- dup_err  out  1  one-cycle strobe: a word with an address already set in the current frame was dropped.

Behaviour:
- Reset (async, any time including mid-frame):
  - vpfs, sbits, cnt = 0.
  - overflow, frame_valid, addr_err, dup_err = 0.
  - Accumulator cleared; FSM goes to IDLE.
- FSM states:
  - IDLE: no frame open. A clst_valid word opens the frame, goes to ACCUM, and that word is processed.
  - ACCUM: frame open; process each clst_valid word.
  - From either state, clst_valid&clst_last goes to DONE.
  - DONE: lasts one cycle, then returns to IDLE. If clst_valid is high during DONE, that word opens the next frame and goes to ACCUM; back-to-back frames need no gap.
- Word processing, per clst_valid word:
  - Null (addr 0x7FF): ignored, no error.
  - Out of range (NUM_STRIPS <= addr <= 0x7FE): dropped; addr_err=1 next cycle.
  - Duplicate (accumulator bit already set): dropped; dup_err=1 next cycle.
  - Otherwise: set accumulator bit addr, acc_cnt += 1, saturating at 2^CNT_W-1.
- Frame close:
  - Cycle after the clst_last word: vpfs, sbits and cnt load the accumulator values, including the last word's contribution.
  - overflow = (new cnt > MAX_CLUSTERS); frame_valid = 1 for one cycle.
  - Accumulator clears in the same cycle.
  - Latency: last word to frame_valid = 1 clock4x.
- Output holding: vpfs, cnt and overflow hold until the next frame close or reset. frame_valid and the error strobes are otherwise 0.
- Empty frame (single null word with last): frame_valid=1, cnt=0, vpfs=0.
- clst_last with clst_valid=0 is ignored.
- Error strobes are per-word and may coincide with frame_valid.

Optional Feature:
- Macro: CLUSTER_SIZE_EXPAND_EN.
- Defined:
  - sbits carries a second accumulator with bits addr..addr+clst_size set, clipped at NUM_STRIPS-1.
  - Overlapping clusters OR together; expansion never affects cnt or dup detection.
- Undefined: no second accumulator; sbits is driven identical to vpfs.

Decomposition:
- Package cluster_pkg holds:
  - NUM_STRIPS, ADDR_W=11, SIZE_W=3, NULL_ADDR=11'h7FF.
  - Packed typedef cluster_t {addr, size}, shared with the packer side.
- One sub-module, cluster_strip_mask:
  - Combinational; maps addr/size to a NUM_STRIPS one-hot plus size mask.
  - Instantiated once, twice when the expansion feature is enabled.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0.
- Assert reset after 2 words of a frame, release, send one word addr 5 with last -> cnt=1, vpfs only bit 5.
- Words addr 0, 767, 1535 (last on third) -> next cycle frame_valid=1, vpfs bits {0,767,1535}, cnt=3, overflow=0.
- Back-to-back frame of 9 distinct addresses in consecutive cycles -> cnt=9, overflow=1, previous frame's bits absent.
- Words addr 1600, addr 0x7FF, addr 10, addr 10 (last) -> addr_err pulse after word 1, dup_err pulse after word 4, no strobe for 0x7FF, cnt=1, vpfs bit 10 only.
- With CLUSTER_SIZE_EXPAND_EN: addr 1533 size 7 plus addr 100 size 2 (last) -> sbits bits 100..102 and 1533..1535, vpfs bits {100,1533}, cnt=2. Without the macro, sbits == vpfs.
